ma_filter: RTL and testbench

Parametrised moving-average (boxcar) shaper that follows the exp_sig_gen source in the filter top level.
- Generalises the fixed v1..v6 filter slots: window length is 2^win_log2, selectable at run time up to 2^LOG2_MAX_LEN.
- Accepts gated (decimated) input via a valid strobe.
- Output is normalised back to ADC scale.

---
 rtl/ma_filter_pkg.sv | 14 +
 rtl/ma_delay_line.sv | 45 ++++
 rtl/ma_filter.sv | 145 ++++++++++++++
 tb/tb_ma_filter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ma_filter_pkg.sv
// ma_filter_pkg: shared widths, window limit and state type
// for the moving-average shaper.
package ma_filter_pkg;

  localparam int SIZE_ADC_DATA    = 12;
  localparam int SIZE_FILTER_DATA = 16;
  localparam int MA_LOG2_MAX_LEN  = 5;

  typedef enum logic {
    ST_FILL,
    ST_RUN
  } ma_state_t;

endpackage

// File: rtl/ma_delay_line.sv
// ma_delay_line: circular sample buffer, 2^LOG2_DEPTH deep.
// Ports: clk, reset (async low), wr_en/wr_data write port,
// win = log2 of tail offset, tail = sample written 2^win ago.
module ma_delay_line
  import ma_filter_pkg::*;
#(
  parameter int DATA_W     = SIZE_ADC_DATA,
  parameter int LOG2_DEPTH = MA_LOG2_MAX_LEN,
  parameter int WIN_W      = $clog2(LOG2_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [WIN_W-1:0]  win,
  output logic [DATA_W-1:0] tail
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;

  // Full-depth window truncates the offset to 0, so the tail
  // is the old word at wr_ptr, read before this edge's write.
  assign rd_ptr = wr_ptr
    - LOG2_DEPTH'((LOG2_DEPTH + 1)'(1) << win);
  assign tail   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/ma_filter.sv
// ma_filter: run-time selectable boxcar average, window 2^win_log2.
// Ports: clk, reset (async low), input_valid/input_data sample in,
// win_log2 window select (clamped), output_data/output_strobe mean,
// peak_data/peak_strobe held peak (only with MA_FILTER_PEAK_EN).
module ma_filter
  import ma_filter_pkg::*;
#(
  parameter int DATA_W       = SIZE_ADC_DATA,
  parameter int OUT_W        = SIZE_FILTER_DATA,
  parameter int LOG2_MAX_LEN = MA_LOG2_MAX_LEN,
  parameter int PEAK_THR     = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              input_valid,
  input  logic [DATA_W-1:0]                 input_data,
  input  logic [$clog2(LOG2_MAX_LEN+1)-1:0] win_log2,
  output logic [OUT_W-1:0]                  output_data,
  output logic                              output_strobe,
  output logic [OUT_W-1:0]                  peak_data,
  output logic                              peak_strobe
);

  localparam int ACC_W  = DATA_W + LOG2_MAX_LEN;
  localparam int FCNT_W = LOG2_MAX_LEN + 1;
  localparam int WIN_W  = $clog2(LOG2_MAX_LEN + 1);

  if (OUT_W < DATA_W || PEAK_THR < 0
      || 64'(PEAK_THR) >= (64'(1) << OUT_W)) begin : g_bad_cfg
    $error("ma_filter: bad OUT_W or PEAK_THR");
  end

  ma_state_t         state, state_nxt;
  logic [WIN_W-1:0]  cur_win, win_req;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [FCNT_W-1:0] fill_cnt, fill_nxt, win_len;
  logic [DATA_W-1:0] tail;
  logic              win_chg, accept;
  logic              out_vld, out_vld_nxt;

  assign win_req = (win_log2 > WIN_W'(LOG2_MAX_LEN))
                 ? WIN_W'(LOG2_MAX_LEN) : win_log2;
  assign win_chg = (win_req != cur_win);
  assign accept  = input_valid && !win_chg;
  assign win_len = FCNT_W'(1) << cur_win;

  ma_delay_line #(
    .DATA_W    (DATA_W),
    .LOG2_DEPTH(LOG2_MAX_LEN),
    .WIN_W     (WIN_W)
  ) u_dly (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (accept),
    .wr_data(input_data),
    .win    (cur_win),
    .tail   (tail)
  );

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    fill_nxt    = fill_cnt;
    out_vld_nxt = 1'b0;
    unique case (1'b1)
      win_chg: begin
        state_nxt = ST_FILL;
        acc_nxt   = '0;
        fill_nxt  = '0;
      end
      accept: begin
        // Tail only leaves the sum once the window is full.
        acc_nxt = acc + ACC_W'(input_data)
          - ((state == ST_RUN) ? ACC_W'(tail) : '0);
        if (fill_cnt != win_len) begin
          fill_nxt = fill_cnt + FCNT_W'(1);
        end
        if (fill_nxt == win_len) begin
          state_nxt = ST_RUN;
        end
        out_vld_nxt = (state_nxt == ST_RUN);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_FILL;
      cur_win       <= '0;
      acc           <= '0;
      fill_cnt      <= '0;
      out_vld       <= 1'b0;
      output_strobe <= 1'b0;
      output_data   <= '0;
    end else begin
      state         <= state_nxt;
      cur_win       <= win_req;
      acc           <= acc_nxt;
      fill_cnt      <= fill_nxt;
      out_vld       <= out_vld_nxt;
      output_strobe <= out_vld;
      if (out_vld) begin
        output_data <= OUT_W'(DATA_W'(acc >> cur_win));
      end
    end
  end

`ifdef MA_FILTER_PEAK_EN
  logic             armed;
  logic [OUT_W-1:0] peak_max;

  // Watches the published stream: arm above threshold, publish
  // the running max on the first strobed value back at/below it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed       <= 1'b0;
      peak_max    <= '0;
      peak_data   <= '0;
      peak_strobe <= 1'b0;
    end else begin
      peak_strobe <= 1'b0;
      if (win_chg) begin
        armed    <= 1'b0;
        peak_max <= '0;
      end else if (output_strobe) begin
        if (output_data > OUT_W'(PEAK_THR)) begin
          armed <= 1'b1;
          if (!armed || output_data > peak_max) begin
            peak_max <= output_data;
          end
        end else if (armed) begin
          peak_data   <= peak_max;
          peak_strobe <= 1'b1;
          armed       <= 1'b0;
        end
      end
    end
  end
`else
  assign peak_data   = '0;
  assign peak_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_ma_filter.sv
// tb_ma_filter: directed vectors for ma_filter, hand-computed
// expectations; builds with or without MA_FILTER_PEAK_EN.
module tb_ma_filter;
  import ma_filter_pkg::*;

  localparam int DATA_W = SIZE_ADC_DATA;
  localparam int OUT_W  = SIZE_FILTER_DATA;
  localparam int LOG2   = 5;
  localparam int WIN_W  = $clog2(LOG2 + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              input_valid = 1'b0;
  logic [DATA_W-1:0] input_data = '0;
  logic [WIN_W-1:0]  win_log2 = '0;
  logic [OUT_W-1:0]  output_data;
  logic              output_strobe;
  logic [OUT_W-1:0]  peak_data;
  logic              peak_strobe;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ma_filter #(
    .DATA_W      (DATA_W),
    .OUT_W       (OUT_W),
    .LOG2_MAX_LEN(LOG2),
    .PEAK_THR    (50)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_data   (input_data),
    .win_log2     (win_log2),
    .output_data  (output_data),
    .output_strobe(output_strobe),
    .peak_data    (peak_data),
    .peak_strobe  (peak_strobe)
  );

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs and step past the next rising edge.
  task automatic drive(input logic v, input int d);
    input_valid = v;
    input_data  = DATA_W'(d);
    @(posedge clk);
    #1;
  endtask

  int t4_v [9] = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
  int t4_d [9] = '{10, 0, 0, 20, 0, 0, 30, 0, 0};
  int t4_s [9] = '{0, 0, 0, 0, 1, 0, 0, 1, 0};
  int t4_o [9] = '{0, 0, 0, 0, 15, 15, 15, 25, 25};
  int t6_d [8] = '{0, 60, 90, 70, 40, 0, 0, 0};

  initial begin
    int nstb;
    int pk_n;
    int pk_at;
`ifdef MA_FILTER_PEAK_EN
    localparam int PK_N = 1;
    localparam int PK_AT = 6;
    localparam int PK_D = 90;
`else
    localparam int PK_N = 0;
    localparam int PK_AT = -1;
    localparam int PK_D = 0;
`endif

    // Held in reset with random stimulus.
    for (int i = 0; i < 5; i++) begin
      input_valid = 1'($urandom_range(0, 1));
      input_data  = DATA_W'($urandom_range(0, 4095));
      win_log2    = WIN_W'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      chk("rst_stb", int'(output_strobe), 0);
      chk("rst_dat", int'(output_data), 0);
      chk("rst_pkd", int'(peak_data), 0);
      chk("rst_pks", int'(peak_strobe), 0);
    end

    // Window 4, constant 100; first edge after release is a
    // window-change edge (cur_win resets to 0) and drops its sample.
    win_log2 = WIN_W'(2);
    input_valid = 1'b1;
    input_data = DATA_W'(100);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1, 100);
      chk("w4_nostb", int'(output_strobe), 0);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 100);
      chk("w4_stb", int'(output_strobe), 1);
      chk("w4_dat", int'(output_data), 100);
    end

    // Window 8 impulse response.
    win_log2 = WIN_W'(3);
    repeat (13) drive(1, 0);
    drive(1, 4000);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0);
      chk("imp_stb", int'(output_strobe), 1);
      chk("imp_dat", int'(output_data), (i < 8) ? 500 : 0);
    end

    // Window 2, sparse valid.
    win_log2 = WIN_W'(1);
    drive(0, 0);
    for (int i = 0; i < 9; i++) begin
      drive(1'(t4_v[i]), t4_d[i]);
      chk("gate_stb", int'(output_strobe), t4_s[i]);
      chk("gate_dat", int'(output_data), t4_o[i]);
    end

    // Window 4 -> 32 with full-scale input.
    win_log2 = WIN_W'(2);
    repeat (8) drive(1, 4095);
    chk("fs4_stb", int'(output_strobe), 1);
    chk("fs4_dat", int'(output_data), 4095);
    win_log2 = WIN_W'(5);
    drive(1, 4095);
    nstb = 0;
    for (int i = 0; i < 32; i++) begin
      drive(1, 4095);
      if (output_strobe) nstb++;
    end
    chk("fs32_nostb", nstb, 0);
    chk("fs32_hold", int'(output_data), 4095);
    drive(1, 4095);
    chk("fs32_stb", int'(output_strobe), 1);
    chk("fs32_dat", int'(output_data), 4095);
    win_log2 = WIN_W'(7);
    for (int i = 0; i < 3; i++) begin
      drive(1, 4095);
      chk("clamp_stb", int'(output_strobe), 1);
      chk("clamp_dat", int'(output_data), 4095);
    end

    // Peak excursion, window 1.
    repeat (3) drive(0, 0);
    win_log2 = WIN_W'(0);
    drive(0, 0);
    pk_n = 0;
    pk_at = -1;
    for (int k = 0; k < 8; k++) begin
      drive(1, t6_d[k]);
      if (k == 5) chk("pk_out40", int'(output_data), 40);
      if (peak_strobe) begin
        pk_n++;
        pk_at = k;
      end
    end
    chk("pk_cnt", pk_n, PK_N);
    chk("pk_at", pk_at, PK_AT);
    chk("pk_dat", int'(peak_data), PK_D);

    // Reset during an excursion: nothing published.
    pk_n = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1, t6_d[k]);
      if (peak_strobe) pk_n++;
    end
    reset = 1'b0;
    #1;
    chk("mid_rst_stb", int'(output_strobe), 0);
    chk("mid_rst_dat", int'(output_data), 0);
    drive(1, 0);
    drive(1, 0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1, (k == 0) ? 40 : 0);
      if (peak_strobe) pk_n++;
    end
    chk("rst_pk_cnt", pk_n, 0);
    chk("rst_pk_dat", int'(peak_data), 0);
    chk("rst_out40", int'(output_data), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
